hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage in-order core (fetch/decode/execute/memoryaccess/writeback). Fills the hazard-handling slot in the core.
- Keeps a shadow scoreboard of destination registers in flight in EX/MEM/WB.
- Generates stall, flush and bubble controls, plus registered operand-forwarding selects for EX.
- Also freezes the pipeline while the dcache has not completed an access.

---
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard control for the 5-stage in-order core.
// It keeps a shadow scoreboard of the destination registers held in EX, MEM
// and WB. From that scoreboard it produces the stall, flush and bubble
// controls, and the registered operand-forwarding selects used by EX.
// While the dcache has not completed an access, the whole pipeline is frozen.
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding. When it is
// not defined, both forward selects stay at 00, and any source hit against a
// live EX/MEM/WB entry stalls the pipeline until that producer has retired.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs1_addr, id_rs2_addr   ID source registers
//   id_uses_rs1, id_uses_rs2   ID actually reads rs1 / rs2
//   id_rd_addr, id_rf_w_en     ID destination register and write enable
//   id_is_load                 ID instruction is a load
//   ex_redirect                EX resolved a taken branch/jump
//   dmem_req, dmem_ready       MEM access pending / dcache completes it
//   stall_if/id/ex/mem         hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   bubble_ex, bubble_wb       NOP into ID/EX, MEM/WB (combinational)
//   flush_id                   invalidate IF/ID (combinational)
//   fwd_a_sel, fwd_b_sel       EX operand source, registered:
//                              00 regfile, 01 MEM alu_out, 10 WB rf_wdata
module hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_rf_w_en,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              bubble_ex,
    output logic              bubble_wb,
    output logic              flush_id,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    // Elaboration guard: the register file must fit in the address width.
    if (NREGS > (32'd1 << REG_AW)) begin : g_param_check
        $error("hazard_ctrl: NREGS exceeds the REG_AW address space");
    end

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wen;
        logic              load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_LOADUSE,
        MODE_REDIRECT,
        MODE_MEMWAIT
    } mode_e;

    sb_entry_t ex_q, mem_q, wb_q;
    mode_e     mode;
    logic      memwait, loaduse;
    logic      a_ex, a_mem, b_ex, b_mem;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // An entry is live only when it writes a non-x0 register.
    function automatic logic src_hit(input logic vld, input logic use_rs,
                                     input logic [REG_AW-1:0] rs,
                                     input sb_entry_t e);
        return vld && use_rs && e.wen && (e.rd != REG_AW'(0)) && (rs == e.rd);
    endfunction

    assign a_ex  = src_hit(id_valid, id_uses_rs1, id_rs1_addr, ex_q);
    assign a_mem = src_hit(id_valid, id_uses_rs1, id_rs1_addr, mem_q);
    assign b_ex  = src_hit(id_valid, id_uses_rs2, id_rs2_addr, ex_q);
    assign b_mem = src_hit(id_valid, id_uses_rs2, id_rs2_addr, mem_q);

`ifdef HAZARD_FWD_EN
    // Only a load still in EX cannot be forwarded in time.
    assign loaduse = (a_ex | b_ex) & ex_q.load;

    // The nearest producer wins: EX (MEM next cycle) over MEM (WB next cycle).
    always_comb begin
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (a_ex)       fwd_a_nxt = 2'b01;
        else if (a_mem) fwd_a_nxt = 2'b10;
        if (b_ex)       fwd_b_nxt = 2'b01;
        else if (b_mem) fwd_b_nxt = 2'b10;
    end
`else
    logic a_wb, b_wb;

    assign a_wb = src_hit(id_valid, id_uses_rs1, id_rs1_addr, wb_q);
    assign b_wb = src_hit(id_valid, id_uses_rs2, id_rs2_addr, wb_q);

    // Without forwarding, every in-flight producer has to drain first.
    assign loaduse   = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
    assign fwd_a_nxt = 2'b00;
    assign fwd_b_nxt = 2'b00;
`endif

    // The WB entry's load flag is never consulted.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign memwait = dmem_req & ~dmem_ready;

    // Priority decision for this cycle.
    always_comb begin
        mode = MODE_NORMAL;
        if (memwait)          mode = MODE_MEMWAIT;
        else if (ex_redirect) mode = MODE_REDIRECT;
        else if (loaduse)     mode = MODE_LOADUSE;
    end

    // Pipeline controls, forced low while reset is asserted.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        bubble_ex = 1'b0;
        bubble_wb = 1'b0;
        flush_id  = 1'b0;
        if (reset) begin
            case (mode)
                MODE_MEMWAIT: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    bubble_wb = 1'b1;
                end
                MODE_REDIRECT: begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                MODE_LOADUSE: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow scoreboard and forward-select registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            case (mode)
                MODE_MEMWAIT: begin
                    wb_q <= '0;
                end
                MODE_REDIRECT, MODE_LOADUSE: begin
                    ex_q      <= '0;
                    mem_q     <= ex_q;
                    wb_q      <= mem_q;
                    fwd_a_sel <= 2'b00;
                    fwd_b_sel <= 2'b00;
                end
                default: begin
                    ex_q      <= '{rd: id_rd_addr, wen: id_rf_w_en & id_valid,
                                   load: id_is_load};
                    mem_q     <= ex_q;
                    wb_q      <= mem_q;
                    fwd_a_sel <= fwd_a_nxt;
                    fwd_b_sel <= fwd_b_nxt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Expected values are hand-derived for both
// builds; HAZARD_FWD_EN selects which set applies.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              id_valid, id_uses_rs1, id_uses_rs2, id_rf_w_en, id_is_load;
    logic [REG_AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic              ex_redirect, dmem_req, dmem_ready;
    logic              stall_if, stall_id, stall_ex, stall_mem;
    logic              bubble_ex, bubble_wb, flush_id;
    logic [1:0]        fwd_a_sel, fwd_b_sel;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.REG_AW(REG_AW), .NREGS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_rd_addr  (id_rd_addr),
        .id_rf_w_en  (id_rf_w_en),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .bubble_ex   (bubble_ex),
        .bubble_wb   (bubble_wb),
        .flush_id    (flush_id),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_id}
    function automatic logic [6:0] ctl();
        return {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_id};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid    = 1'b0;
        id_rs1_addr = '0;
        id_rs2_addr = '0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        id_rd_addr  = '0;
        id_rf_w_en  = 1'b0;
        id_is_load  = 1'b0;
        ex_redirect = 1'b0;
        dmem_req    = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wen,
                          input logic ld);
        id_valid    = 1'b1;
        id_rs1_addr = rs1;
        id_uses_rs1 = u1;
        id_rs2_addr = rs2;
        id_uses_rs2 = u2;
        id_rd_addr  = rd;
        id_rf_w_en  = wen;
        id_is_load  = ld;
    endtask

    task automatic flush_pipe();
        idle_inputs();
        repeat (3) tick();
    endtask

    // Hold an instruction in ID until it is accepted; report cycles stalled.
    // Returns one cycle after acceptance, so fwd sels belong to its EX cycle.
    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wen,
                         input logic ld, output int stalls);
        stalls = 0;
        set_id(rs1, u1, rs2, u2, rd, wen, ld);
        #1;
        while (stall_id === 1'b1 && stalls < 10) begin
            stalls++;
            tick();
        end
        tick();
        id_valid   = 1'b0;
        id_rf_w_en = 1'b0;
        id_is_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            {id_valid, id_uses_rs1, id_uses_rs2, id_rf_w_en, id_is_load} = 5'($urandom);
            {ex_redirect, dmem_req, dmem_ready} = 3'($urandom);
            id_rs1_addr = 5'($urandom);
            id_rs2_addr = 5'($urandom);
            id_rd_addr  = 5'($urandom);
            if (c == 0) begin
                dmem_req   = 1'b1;
                dmem_ready = 1'b0;
            end
            #1;
            checks++;
            if ({ctl(), fwd_a_sel, fwd_b_sel} !== 11'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", c,
                         {ctl(), fwd_a_sel, fwd_b_sel}, 11'b0);
            end
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        checks++;
        if ({ctl(), fwd_a_sel, fwd_b_sel} !== 11'b0) begin
            errors++;
            $display("FAIL first_normal: got %b expected %b",
                     {ctl(), fwd_a_sel, fwd_b_sel}, 11'b0);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, st);      // add x5
        checks++;
        if (st !== 0) begin
            errors++;
            $display("FAIL b2b_producer_stalls: got %0d expected 0", st);
        end
        issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, st);      // add x6,x5,x1
        checks++;
        if (st !== (FWD ? 0 : 3)) begin
            errors++;
            $display("FAIL b2b_stalls: got %0d expected %0d", st, FWD ? 0 : 3);
        end
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== (FWD ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL b2b_fwd: got %b expected %b", {fwd_a_sel, fwd_b_sel},
                     FWD ? 4'b0100 : 4'b0000);
        end
        // Two writers of x5 in flight: the younger (EX) one must win.
        flush_pipe();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, st);
        issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, st);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, st);
        checks++;
        if ({st[3:0], fwd_a_sel} !== (FWD ? 6'b0000_01 : 6'b0011_00)) begin
            errors++;
            $display("FAIL nearest_producer: got stalls %0d fwd_a %b expected stalls %0d fwd_a %b",
                     st, fwd_a_sel, FWD ? 0 : 3, FWD ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_fwd_mem();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, st);      // add x5
        issue(5'd2, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, st);      // unrelated
        issue(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, st);      // add x6,x5,x1
        checks++;
        if (st !== (FWD ? 0 : 2)) begin
            errors++;
            $display("FAIL gap1_stalls: got %0d expected %0d", st, FWD ? 0 : 2);
        end
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== (FWD ? 4'b1000 : 4'b0000)) begin
            errors++;
            $display("FAIL gap1_fwd: got %b expected %b", {fwd_a_sel, fwd_b_sel},
                     FWD ? 4'b1000 : 4'b0000);
        end
    endtask

    task automatic test_load_use();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, st);      // lw x7
        set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);          // add x8,x7,x7
        #1;
        checks++;
        if (ctl() !== 7'b1100100) begin
            errors++;
            $display("FAIL load_use_ctl: got %b expected %b", ctl(), 7'b1100100);
        end
        issue(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, st);
        checks++;
        if (st !== (FWD ? 1 : 3)) begin
            errors++;
            $display("FAIL load_use_stalls: got %0d expected %0d", st, FWD ? 1 : 3);
        end
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== (FWD ? 4'b1010 : 4'b0000)) begin
            errors++;
            $display("FAIL load_use_fwd: got %b expected %b", {fwd_a_sel, fwd_b_sel},
                     FWD ? 4'b1010 : 4'b0000);
        end
    endtask

    task automatic test_memwait();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, st);      // add x5
        issue(5'd2, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, st);      // add x9
        set_id(5'd9, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);         // add x10,x9,x5
        dmem_req   = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (ctl() !== 7'b1111010) begin
                errors++;
                $display("FAIL memwait_ctl cycle %0d: got %b expected %b", c, ctl(), 7'b1111010);
            end
            tick();
            checks++;
            if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
                errors++;
                $display("FAIL memwait_fwd_hold cycle %0d: got %b expected %b", c,
                         {fwd_a_sel, fwd_b_sel}, 4'b0000);
            end
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl() & 7'b0011010) begin
            errors++;
            $display("FAIL memwait_release: got %b expected stall_ex/mem/bubble_wb low", ctl());
        end
        issue(5'd9, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0, st);
        checks++;
        if ({st[3:0], fwd_a_sel, fwd_b_sel} !== (FWD ? 8'b0000_0110 : 8'b0011_0000)) begin
            errors++;
            $display("FAIL memwait_sb_held: got stalls %0d fwd %b%b expected stalls %0d fwd %b",
                     st, fwd_a_sel, fwd_b_sel, FWD ? 0 : 3, FWD ? 4'b0110 : 4'b0000);
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, st);      // lw x7
        set_id(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);          // would load-use
        ex_redirect = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b0000101) begin
            errors++;
            $display("FAIL redirect_ctl: got %b expected %b", ctl(), 7'b0000101);
        end
        tick();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL redirect_fwd: got %b expected %b", {fwd_a_sel, fwd_b_sel}, 4'b0000);
        end
        ex_redirect = 1'b0;
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0);
        #1;
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++;
            $display("FAIL redirect_next: got %b expected %b", ctl(), 7'b0000000);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_x0();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, st);      // lw x0
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, st);     // reads x0 twice
        checks++;
        if ({st[3:0], fwd_a_sel, fwd_b_sel} !== 8'b0) begin
            errors++;
            $display("FAIL x0_no_hazard: got stalls %0d fwd %b%b expected stalls 0 fwd 0000",
                     st, fwd_a_sel, fwd_b_sel);
        end
        set_id(5'd3, 1'b1, 5'd4, 1'b1, 5'd13, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        dmem_req    = 1'b1;
        dmem_ready  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (ctl() !== 7'b1111010) begin
                errors++;
                $display("FAIL redirect_in_memwait cycle %0d: got %b expected %b", c, ctl(),
                         7'b1111010);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b0000101) begin
            errors++;
            $display("FAIL redirect_on_ready: got %b expected %b", ctl(), 7'b0000101);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        int st;
        flush_pipe();
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, st);      // lw x7
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        #1;
        checks++;
        if (ctl() !== 7'b1100100) begin
            errors++;
            $display("FAIL pre_reset_stall: got %b expected %b", ctl(), 7'b1100100);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_mid_stall: got %b expected %b", ctl(), 7'b0000000);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++;
            $display("FAIL after_reset_stall: got %b expected %b", ctl(), 7'b0000000);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_fwd_mem();
        test_load_use();
        test_memwait();
        test_redirect();
        test_x0();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
